// File: rtl/spi_byte_fifo_if.sv
//------------------------------------------------------------------------------
// spi_byte_fifo_if : host FIFO bus and SPI-core handshake signals (rev 1.0)
//------------------------------------------------------------------------------
`default_nettype none

interface spi_byte_fifo_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       clr_err;
  logic       tx_full;
  logic [4:0] tx_count;
  logic       rx_empty;
  logic [4:0] rx_count;
  logic       tx_ovf;
  logic       rx_ovf;
  logic       timeout_err;
  logic       xfer_active;
  logic [7:0] spi_data_in;
  logic       spi_ready_send;
  logic       spi_busy;
  logic [7:0] spi_data_out;

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err, spi_busy, spi_data_out,
    output rd_data, tx_full, tx_count, rx_empty, rx_count,
           tx_ovf, rx_ovf, timeout_err, xfer_active,
           spi_data_in, spi_ready_send
  );

  modport master (
    output wr_en, wr_data, rd_en, clr_err, spi_busy, spi_data_out,
    input  rd_data, tx_full, tx_count, rx_empty, rx_count,
           tx_ovf, rx_ovf, timeout_err, xfer_active,
           spi_data_in, spi_ready_send
  );
endinterface

`default_nettype wire

// File: rtl/spi_byte_fifo.sv
//------------------------------------------------------------------------------
// spi_byte_fifo : TX/RX byte FIFOs feeding a one-byte-at-a-time SPI launcher (rev 1.0)
//------------------------------------------------------------------------------
`default_nettype none

module spi_byte_fifo #(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  wire logic       clk,
  input  wire logic       rst,
  spi_byte_fifo_if.slave  bus
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              TW       = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [4:0]      FULL_CNT = 5'(DEPTH);
  localparam logic [TW-1:0]   TMO_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t        state;
  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [4:0]    tx_cnt, rx_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          tx_ovf_q, rx_ovf_q, tmo_q, ready_q;
  logic [7:0]    data_in_q;

  logic tx_full_w, rx_empty_w, rx_full_w;
  logic tx_pop, tx_push, tx_drop;
  logic rx_done, rx_pop, rx_push, rx_drop, tmo_hit;

  assign tx_full_w  = (tx_cnt == FULL_CNT);
  assign rx_empty_w = (rx_cnt == 5'd0);
  assign rx_full_w  = (rx_cnt == FULL_CNT);

  // A same-cycle pop frees a slot, so a push to a full FIFO still lands.
  assign tx_pop  = (state == IDLE) && (tx_cnt != 5'd0) && !bus.spi_busy;
  assign tx_push = bus.wr_en && (!tx_full_w || tx_pop);
  assign tx_drop = bus.wr_en && tx_full_w && !tx_pop;

  assign rx_done = (state == WAIT_DONE) && !bus.spi_busy;
  assign rx_pop  = bus.rd_en && !rx_empty_w;
  assign rx_push = rx_done && (!rx_full_w || rx_pop);
  assign rx_drop = rx_done && rx_full_w && !rx_pop;
  assign tmo_hit = (state == WAIT_BUSY) && !bus.spi_busy && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus.wr_data;
    if (rx_push) rx_mem[rx_wp] <= bus.spi_data_out;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= 5'd0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= 5'd0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt + {4'd0, tx_push} - {4'd0, tx_pop};
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + {4'd0, rx_push} - {4'd0, rx_pop};
    end
  end

  // A flag raised in the same cycle as clr_err survives the clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_ovf_q <= 1'b0;
      rx_ovf_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      tx_ovf_q <= (tx_ovf_q && !bus.clr_err) || tx_drop;
      rx_ovf_q <= (rx_ovf_q && !bus.clr_err) || rx_drop;
      tmo_q    <= (tmo_q    && !bus.clr_err) || tmo_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      ready_q   <= 1'b0;
      data_in_q <= 8'h00;
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_pop) begin
            data_in_q <= tx_mem[tx_rp];
            ready_q   <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          tmo_cnt <= '0;
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.spi_busy)  state   <= WAIT_DONE;
          else if (tmo_hit)  state   <= IDLE;
          else               tmo_cnt <= tmo_cnt + 1'b1;
        end
        WAIT_DONE: begin
          if (!bus.spi_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_data        = rx_empty_w ? 8'h00 : rx_mem[rx_rp];
  assign bus.tx_full        = tx_full_w;
  assign bus.tx_count       = tx_cnt;
  assign bus.rx_empty       = rx_empty_w;
  assign bus.rx_count       = rx_cnt;
  assign bus.tx_ovf         = tx_ovf_q;
  assign bus.rx_ovf         = rx_ovf_q;
  assign bus.timeout_err    = tmo_q;
  assign bus.xfer_active    = (state != IDLE);
  assign bus.spi_data_in    = data_in_q;
  assign bus.spi_ready_send = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_byte_fifo.sv
//------------------------------------------------------------------------------
// tb_spi_byte_fifo : scoreboard bench with a behavioural SPI-core model (rev 1.0)
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_spi_byte_fifo;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_byte_fifo_if bus ();
  spi_byte_fifo #(.DEPTH(DEPTH), .BUSY_TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int compared = 0, mismatched = 0;
  logic [7:0] launch_exp [$];
  logic [7:0] rx_model   [$];
  logic [7:0] rd_exp     [$];
  bit exp_tx_ovf = 0, exp_rx_ovf = 0, exp_tout = 0;
  int pulses = 0, cyc = 0, last_pulse = -100;

  // SPI core model: 0 normal, 1 never raises busy, 2 holds busy high
  int spi_mode = 0, spi_delay = 2, spi_hold = 1, spi_st = 0, spi_cnt = 0;
  bit spi_fixed = 0, spi_rand = 0, spi_abort = 0, drop_next = 0;
  logic [7:0] spi_ret = 8'h36, ret_b;

  task automatic check(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (rst && bus.spi_ready_send) begin
        pulses++;
        check("launch_gap_ok", int'((cyc - last_pulse) >= 3), 1);
        last_pulse = cyc;
        if (launch_exp.size() == 0) check("unexpected_launch_byte", int'(bus.spi_data_in), 256);
        else check("launch_byte", int'(bus.spi_data_in), int'(launch_exp.pop_front()));
      end
      if (rst && bus.rd_en) begin
        if (rd_exp.size() > 0) check("rd_data", int'(bus.rd_data), int'(rd_exp.pop_front()));
        else begin
          check("rd_empty_data", int'(bus.rd_data), 0);
          check("rd_empty_flag", int'(bus.rx_empty), 1);
        end
      end
    end
  end

  initial begin
    bus.spi_busy = 1'b0;
    bus.spi_data_out = 8'h00;
    forever begin
      @(posedge clk); #2;
      case (spi_st)
        0: begin
          bus.spi_busy = (spi_mode == 2);
          if (bus.spi_ready_send && spi_mode == 0) begin
            if (spi_rand) begin
              spi_delay = $urandom_range(1, 3);
              spi_hold  = $urandom_range(1, 4);
            end
            spi_cnt = spi_delay;
            spi_st  = 1;
          end
        end
        1: begin
          spi_cnt--;
          if (spi_cnt == 0) begin
            bus.spi_busy = 1'b1;
            spi_cnt = spi_hold;
            spi_st  = 2;
          end
        end
        default: begin
          spi_cnt--;
          if (spi_cnt == 0) begin
            ret_b = spi_fixed ? spi_ret : 8'($urandom);
            bus.spi_busy = 1'b0;
            bus.spi_data_out = ret_b;
            if (spi_abort) spi_abort = 0;
            else if (rx_model.size() < DEPTH) rx_model.push_back(ret_b);
            else exp_rx_ovf = 1;
            spi_st = 0;
          end
        end
      endcase
      drop_next = (spi_st == 2 && spi_cnt == 1);
    end
  end

  task automatic step(bit we, logic [7:0] d, bit re);
    bus.wr_en = we;
    bus.wr_data = d;
    bus.rd_en = re;
    if (we) begin
      if (launch_exp.size() < DEPTH) launch_exp.push_back(d);
      else exp_tx_ovf = 1;
    end
    if (re && rx_model.size() > 0) rd_exp.push_back(rx_model.pop_front());
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic wait_idle(int limit, string name);
    int n = 0;
    while (!(launch_exp.size() == 0 && spi_st == 0 && !bus.xfer_active && !bus.spi_busy) && n < limit) begin
      step(0, 8'h00, 0);
      n++;
    end
    check({name, "_idle_in_time"}, int'(n < limit), 1);
  endtask

  task automatic push_wait(logic [7:0] d);
    int n = 0;
    while (launch_exp.size() >= DEPTH && n < 200) begin
      step(0, 8'h00, 0);
      n++;
    end
    step(1, d, 0);
  endtask

  task automatic drain_rx(string name);
    int n = 0;
    while (rx_model.size() > 0 && n < 50) begin
      step(0, 8'h00, 1);
      n++;
    end
    check({name, "_rx_empty"}, int'(bus.rx_empty), 1);
  endtask

  task automatic clear_err();
    bus.clr_err = 1'b1;
    exp_tx_ovf = 0;
    exp_rx_ovf = 0;
    exp_tout = 0;
    step(0, 8'h00, 0);
  endtask

  initial begin
    int p0, n;
    rst = 1'b0;
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.rd_en = 1'b0; bus.clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_full", int'(bus.tx_full), 0);
    check("rst_rx_empty", int'(bus.rx_empty), 1);
    check("rst_rd_data", int'(bus.rd_data), 0);
    check("rst_data_in", int'(bus.spi_data_in), 0);
    check("rst_ready", int'(bus.spi_ready_send), 0);
    check("rst_active", int'(bus.xfer_active), 0);
    check("rst_counts", int'({bus.tx_count, bus.rx_count}), 0);
    check("rst_flags", int'({bus.tx_ovf, bus.rx_ovf, bus.timeout_err}), 0);
    rst = 1'b1;
    step(0, 8'h00, 0);

    // Single transfer with fixed SPI timing and reply
    spi_fixed = 1; spi_ret = 8'h36; spi_delay = 2; spi_hold = 1;
    p0 = pulses;
    step(1, 8'h13, 0);
    wait_idle(50, "single");
    check("single_pulses", pulses - p0, 1);
    check("single_data_in", int'(bus.spi_data_in), 8'h13);
    check("single_rx_count", int'(bus.rx_count), rx_model.size());
    check("single_rd_data", int'(bus.rd_data), 8'h36);
    drain_rx("single");
    spi_fixed = 0;

    // TX overflow while the core is held busy
    spi_mode = 2;
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    p0 = pulses;
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 0);
    check("ovf_tx_count", int'(bus.tx_count), launch_exp.size());
    check("ovf_tx_full", int'(bus.tx_full), 1);
    check("ovf_tx_ovf", int'(bus.tx_ovf), int'(exp_tx_ovf));
    spi_mode = 0;
    wait_idle(200, "ovf");
    check("ovf_pulses", pulses - p0, 4);
    drain_rx("ovf");
    clear_err();
    check("ovf_cleared", int'(bus.tx_ovf), 0);

    // RX overflow after five unread transfers
    for (int i = 0; i < 5; i++) push_wait(8'($urandom));
    wait_idle(300, "rxfull");
    check("rxfull_count", int'(bus.rx_count), rx_model.size());
    check("rxfull_ovf", int'(bus.rx_ovf), int'(exp_rx_ovf));
    clear_err();
    check("rxfull_cleared", int'(bus.rx_ovf), 0);

    // Host pop coincides with completion while RX is full
    push_wait(8'hA5);
    n = 0;
    while (!drop_next && n < 100) begin
      step(0, 8'h00, 0);
      n++;
    end
    check("coinc_found", int'(n < 100), 1);
    step(0, 8'h00, 1);
    wait_idle(50, "coinc");
    check("coinc_rx_count", int'(bus.rx_count), rx_model.size());
    check("coinc_rx_ovf", int'(bus.rx_ovf), int'(exp_rx_ovf));
    drain_rx("coinc");

    // Busy never rises: timeout on the 16th WAIT_BUSY cycle
    spi_mode = 1;
    p0 = int'(bus.rx_count);
    step(1, 8'hC3, 0);
    n = 0;
    while (!bus.spi_ready_send && n < 20) begin
      step(0, 8'h00, 0);
      n++;
    end
    check("tmo_launch_seen", int'(n < 20), 1);
    repeat (16) step(0, 8'h00, 0);
    check("tmo_not_yet", int'(bus.timeout_err), 0);
    check("tmo_still_active", int'(bus.xfer_active), 1);
    exp_tout = 1;
    step(0, 8'h00, 0);
    check("tmo_flag", int'(bus.timeout_err), int'(exp_tout));
    check("tmo_idle", int'(bus.xfer_active), 0);
    check("tmo_rx_count", int'(bus.rx_count), p0);
    spi_mode = 0;
    clear_err();
    check("tmo_cleared", int'(bus.timeout_err), 0);

    // Randomized traffic
    spi_rand = 1;
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 1) == 1) && (launch_exp.size() < DEPTH), 8'($urandom),
           $urandom_range(0, 2) == 0);
    wait_idle(300, "rand");
    check("rand_rx_count", int'(bus.rx_count), rx_model.size());
    check("rand_flags", int'({bus.tx_ovf, bus.rx_ovf, bus.timeout_err}),
          int'({exp_tx_ovf, exp_rx_ovf, exp_tout}));
    drain_rx("rand");
    clear_err();
    spi_rand = 0;

    // Reset asserted during WAIT_DONE
    spi_delay = 1; spi_hold = 8;
    step(1, 8'h5A, 0);
    n = 0;
    while (!bus.spi_busy && n < 20) begin
      step(0, 8'h00, 0);
      n++;
    end
    check("rstmid_busy_seen", int'(n < 20), 1);
    spi_abort = 1;
    rst = 1'b0;
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    launch_exp.delete(); rx_model.delete(); rd_exp.delete();
    exp_tx_ovf = 0; exp_rx_ovf = 0; exp_tout = 0;
    rst = 1'b1;
    p0 = pulses;
    repeat (12) step(0, 8'h00, 0);
    check("rstmid_busy_dropped", int'(bus.spi_busy), 0);
    check("rstmid_counts", int'({bus.tx_count, bus.rx_count}), 0);
    check("rstmid_rx_empty", int'(bus.rx_empty), 1);
    check("rstmid_active", int'(bus.xfer_active), 0);
    check("rstmid_pulses", pulses - p0, 0);
    check("rstmid_data_in", int'(bus.spi_data_in), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/spi_byte_fifo.md
SPI_BYTE_FIFO -- requirements
Module: spi_byte_fifo

Interface
REQ-001 Parameters SHALL be, one per line:
- DEPTH, 4, entries per FIFO (power of two, 2..16).
- BUSY_TIMEOUT, 16, clk cycles allowed for spi_busy to rise after a launch.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- wr_en  in  1  host push into TX FIFO.
- wr_data  in  8  byte to transmit.
- rd_en  in  1  host pop from RX FIFO.
- rd_data  out  8  RX FIFO head (show-ahead).
- clr_err  in  1  clears sticky error flags.
- tx_full  out  1  TX FIFO full.
- tx_count  out  5  TX occupancy.
- rx_empty  out  1  RX FIFO empty.
- rx_count  out  5  RX occupancy.
- tx_ovf  out  1  sticky; push to full TX FIFO.
- rx_ovf  out  1  sticky; RX byte dropped, RX FIFO full.
- timeout_err  out  1  sticky; spi_busy never rose.
- xfer_active  out  1  FSM not in IDLE.
- spi_data_in  out  8  byte to SPI core.
- spi_ready_send  out  1  one-cycle launch strobe to SPI core.
- spi_busy  in  1  SPI core busy.
- spi_data_out  in  8  byte received by SPI core.

Function
REQ-003 TX and RX SHALL be independent circular FIFOs of DEPTH bytes, with wrap-around pointers and a separate count (0..DEPTH).
REQ-004 A TX push SHALL occur when wr_en=1 and tx_full=0. When wr_en=1 and tx_full=1, the write is dropped and tx_ovf is set in the next cycle.
REQ-005 rd_data SHALL equal the RX head when rx_empty=0, and 8'h00 otherwise. A pop SHALL occur when rd_en=1 and rx_empty=0. rd_en on an empty FIFO has no effect.
REQ-006 The FSM SHALL have four states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-007 IDLE->LAUNCH SHALL occur when tx_count>0 and spi_busy=0. On this transition the TX head is popped into a holding register.
REQ-008 In LAUNCH, spi_ready_send=1 for exactly one cycle with spi_data_in = holding register. Next state is WAIT_BUSY.
REQ-009 spi_data_in SHALL hold its value until the next launch.
REQ-010 WAIT_BUSY->WAIT_DONE SHALL occur on spi_busy=1. If BUSY_TIMEOUT cycles elapse first: go to IDLE, set timeout_err, discard the byte, push nothing to RX.
REQ-011 WAIT_DONE->IDLE SHALL occur on spi_busy=0. In that same cycle spi_data_out is pushed to RX. If RX is full at that moment, the byte is dropped and rx_ovf is set.
REQ-012 Minimum spacing between consecutive spi_ready_send pulses SHALL be 3 cycles.
REQ-013 Simultaneous push and pop on the same FIFO in one cycle SHALL both take effect:
- count unchanged;
- allowed when full: the pop frees the slot, so no tx_ovf;
- allowed when empty: only the push takes effect.
REQ-014 An RX push in WAIT_DONE and a host pop in the same cycle with RX full SHALL store the byte with no rx_ovf.
REQ-015 A TX FSM pop and a host push in the same cycle SHALL both take effect.
REQ-016 clr_err=1 SHALL clear all sticky flags next cycle. A new error in the same cycle wins, and its flag stays set.
REQ-017 xfer_active SHALL be 1 in every state except IDLE.
REQ-018 tx_full SHALL equal (tx_count==DEPTH), and rx_empty SHALL equal (rx_count==0).

Reset
REQ-019 With rst=0 at a rising edge, the block SHALL return to its reset values regardless of state, including mid-transfer:
- FSM to IDLE, pointers and counts to 0, flags cleared;
- tx_full=0, rx_empty=1, rd_data=0, spi_data_in=0, spi_ready_send=0, xfer_active=0, timeout counter 0.
REQ-020 A transfer aborted by reset SHALL NOT push anything to RX after reset releases.

Verification
REQ-021 Write 8'h13, SPI model asserts busy 2 cycles after launch, returns 8'h36 -> spi_data_in=8'h13, a single ready_send pulse, rx_count=1, rd_data=8'h36.
REQ-022 Write 8'h01..8'h05 back-to-back with DEPTH=4 and SPI held busy -> tx_count stays 4, tx_ovf=1, bytes 8'h01..8'h04 are launched in order, and 8'h05 is never sent.
REQ-023 Complete 5 transfers without reading -> rx_count=4, rx_ovf=1, and the pops return the first four received bytes.
REQ-024 Launch with spi_busy stuck at 0 -> timeout_err=1 after 16 cycles in WAIT_BUSY, FSM returns to IDLE, rx_count unchanged; clr_err then clears the flag.
REQ-025 Drop rst to 0 during WAIT_DONE, then release; SPI later drops busy -> all counts 0, no RX push, spi_ready_send stays 0.
REQ-026 With RX full, host pop coincides with transfer completion -> rx_count stays 4, rx_ovf=0, and the new byte appears at the tail.
